write_back: RTL

WRITE_BACK -- requirements
Module: write_back

---
 rtl/core_pkg.sv | 37 +++
 rtl/regfile.sv | 31 +++
 rtl/write_back.sv | 128 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the commit (write-back) stage.
//  - wselector bit positions
//  - commit FSM state encoding
//  - PC step and small helpers that decode the write selector
package core_pkg;

  localparam int unsigned WS_REG_DATA = 1;  // reg write from data
  localparam int unsigned WS_PC_JUMP  = 2;  // PC write from pc_jump
  localparam int unsigned WS_REG_MEM  = 3;  // reg write from mem_data

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } wb_state_e;

  // Exec results captured when a commit is accepted.
  typedef struct packed {
    logic [3:0]  wsel;
    logic [31:0] data;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic [31:0] pc_jump;
  } wb_req_t;

  function automatic logic reg_we(input logic [3:0] wsel);
    return wsel[WS_REG_MEM] | wsel[WS_REG_DATA];
  endfunction

  // Load result has priority over the ALU/link result.
  function automatic logic [31:0] reg_wdata(input wb_req_t req);
    return req.wsel[WS_REG_MEM] ? req.mem_data : req.data;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit register file.
//  - one synchronous write port (we_i/waddr_i/wdata_i)
//  - two asynchronous read ports (raddr_a_i -> rdata_a_o, raddr_b_i -> rdata_b_o)
//  - rstn (synchronous, active-low) clears every entry
// Register 0 is hardwired to zero: writes to it are dropped, reads return 0.
module regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];

endmodule

// File: rtl/write_back.sv
// Commit (write-back) stage: latches one set of exec results on an enable
// pulse, applies the register and PC updates one cycle later, then pulses done.
// Timeline: enable in cycle N -> COMMIT in N+1 -> DONE (done=1, new state
// visible) in N+2 -> IDLE. enable outside IDLE is dropped.
//
// Ports:
//  clk, rstn          clock, synchronous active-low reset
//  enable             exec results valid (sampled only in IDLE)
//  done               one-cycle pulse, commit complete
//  wselector          [1] reg<-data, [2] pc<-pc_jump, [3] reg<-mem_data, [0] reserved
//  data, mem_data     register write sources
//  rd                 destination register
//  pc_jump            branch/jump target
//  pc                 architectural PC
//  rs_idx/rs_val,
//  rt_idx/rt_val      asynchronous register reads
//
// Build option: define WB_FORWARD_EN to forward the pending register write to
// the read ports while in COMMIT.
module write_back
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        done,
  input  logic [3:0]  wselector,
  input  logic [31:0] data,
  input  logic [31:0] mem_data,
  input  logic [4:0]  rd,
  input  logic [31:0] pc_jump,
  output logic [31:0] pc,
  input  logic [4:0]  rs_idx,
  input  logic [4:0]  rt_idx,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val
);

  wb_state_e   state_q, state_d;
  wb_req_t     req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        done_q, done_d;

  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rs, rf_rt;

  // Reserved selector bit carries no meaning.
  logic unused_wsel0;
  assign unused_wsel0 = req_q.wsel[0];

  assign rf_wdata = reg_wdata(req_q);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          req_d.wsel     = wselector;
          req_d.data     = data;
          req_d.mem_data = mem_data;
          req_d.rd       = rd;
          req_d.pc_jump  = pc_jump;
          state_d        = COMMIT;
        end
      end
      COMMIT: begin
        rf_we   = reg_we(req_q.wsel);
        pc_d    = req_q.wsel[WS_PC_JUMP] ? req_q.pc_jump : pc_q + PC_STEP;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over everything, so a reset edge in COMMIT drops the writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q   <= '0;
      pc_q    <= RESET_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  regfile u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .we_i      (rf_we),
    .waddr_i   (req_q.rd),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs_idx),
    .rdata_a_o (rf_rs),
    .raddr_b_i (rt_idx),
    .rdata_b_o (rf_rt)
  );

`ifdef WB_FORWARD_EN
  logic fwd_vld;
  assign fwd_vld = (state_q == COMMIT) && reg_we(req_q.wsel) && (req_q.rd != 5'd0);
  assign rs_val  = (fwd_vld && (rs_idx == req_q.rd)) ? rf_wdata : rf_rs;
  assign rt_val  = (fwd_vld && (rt_idx == req_q.rd)) ? rf_wdata : rf_rt;
`else
  assign rs_val  = rf_rs;
  assign rt_val  = rf_rt;
`endif

  assign done = done_q;
  assign pc   = pc_q;

endmodule
